// File: rtl/memory_oam_dma_if.sv
// CPU-side FF46 control signals plus the source-read and OAM-write
// bus of the OAM DMA engine.
interface memory_oam_dma_if;
  logic [15:0] address_bus;
  logic        nread;
  logic        nwrite;
  logic        nsel;
  logic [15:0] dma_address;
  logic [7:0]  dma_data_in;
  logic        dma_nread;
  logic [7:0]  oam_address;
  logic [7:0]  oam_data;
  logic        oam_nwrite;
  logic        dma_active;

  modport master (
    output address_bus, nread, nwrite, nsel,
    output dma_data_in,
    input  dma_address, dma_nread,
    input  oam_address, oam_data, oam_nwrite,
    input  dma_active
  );

  modport slave (
    input  address_bus, nread, nwrite, nsel,
    input  dma_data_in,
    output dma_address, dma_nread,
    output oam_address, oam_data, oam_nwrite,
    output dma_active
  );
endinterface

// File: rtl/memory_oam_dma.sv
// OAM DMA engine: a write to FF46 copies OAM_LEN bytes from
// {src_hi, idx} into OAM, one read cycle and one write cycle per byte.
module memory_oam_dma #(
  parameter int OAM_LEN = 160
) (
  input  logic clock,
  input  logic reset,
  inout  wire  [7:0] data_bus,
  memory_oam_dma_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST = 8'(OAM_LEN - 1);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  src_hi;
  logic [7:0]  idx;
  logic [7:0]  byte_q;
  logic [15:0] dma_addr_q;
  logic [7:0]  oam_addr_q;
  logic [7:0]  oam_data_q;
  logic        ff46_wr;
  logic        ff46_rd;
  logic        last;
  logic [15:0] unused_addr;

  // The address is decoded outside; nsel alone qualifies this register.
  assign unused_addr = bus.address_bus;

  assign ff46_wr = !bus.nsel && !bus.nwrite;
  assign ff46_rd = !bus.nsel && !bus.nread;
  assign last    = idx >= LAST;

  // FF46 reads return src_hi; bus is released otherwise.
  assign data_bus = ff46_rd ? src_hi : 8'hzz;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and strobes; idle outputs hold the last strobed values.
  always_comb begin
    state_nx        = state;
    bus.dma_nread   = 1'b1;
    bus.oam_nwrite  = 1'b1;
    bus.dma_active  = state != IDLE;
    bus.dma_address = dma_addr_q;
    bus.oam_address = oam_addr_q;
    bus.oam_data    = oam_data_q;
    unique case (state)
      IDLE:  state_nx = IDLE;
      START: state_nx = READ;
      READ: begin
        state_nx        = WRITE;
        bus.dma_nread   = 1'b0;
        bus.dma_address = {src_hi, idx};
      end
      WRITE: begin
        state_nx        = last ? IDLE : READ;
        bus.oam_nwrite  = 1'b0;
        bus.oam_address = idx;
        bus.oam_data    = byte_q;
      end
    endcase
    if (ff46_wr) state_nx = START;
  end

  // Source register, byte index and held output values.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_hi     <= 8'hFF;
      idx        <= 8'h00;
      byte_q     <= 8'h00;
      dma_addr_q <= 16'h0000;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
    end else begin
      unique case (state)
        IDLE:  ;
        START: idx <= 8'h00;
        READ: begin
          byte_q     <= bus.dma_data_in;
          dma_addr_q <= {src_hi, idx};
        end
        WRITE: begin
          oam_addr_q <= idx;
          oam_data_q <= byte_q;
          if (!last) idx <= idx + 8'd1;
        end
      endcase
      if (ff46_wr) begin
        src_hi <= data_bus;
        idx    <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_memory_oam_dma.sv
// Bench for memory_oam_dma: source memory and OAM are modelled as
// arrays; expected contents come from the copy rule oam[i] = mem[{hi,i}].
module tb_memory_oam_dma;
  localparam int OAM_LEN = 160;

  logic clock = 1'b0;
  logic reset = 1'b1;
  wire  [7:0] data_bus;
  logic drv = 1'b0;
  logic [7:0] drv_val = 8'h00;

  assign data_bus = drv ? drv_val : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (data_bus[g]);
  end

  memory_oam_dma_if bus ();

  memory_oam_dma #(.OAM_LEN(OAM_LEN)) dut (
    .clock(clock),
    .reset(reset),
    .data_bus(data_bus),
    .bus(bus)
  );

  always #5 clock = ~clock;

  logic [7:0]  src_mem [0:65535];
  logic [7:0]  oam     [0:255];
  logic [7:0]  exp_oam [0:255];
  int          wcnt    [0:255];
  int          both_low = 0;
  int          nwr = 0;
  logic [15:0] rq[$];
  int          errors = 0;
  int          checks = 0;

  assign bus.dma_data_in = src_mem[bus.dma_address];

  // OAM and source-read observers.
  always @(negedge clock) begin
    if (!bus.oam_nwrite) begin
      oam[bus.oam_address] = bus.oam_data;
      wcnt[bus.oam_address] = wcnt[bus.oam_address] + 1;
      nwr = nwr + 1;
    end
    if (!bus.dma_nread) rq.push_back(bus.dma_address);
    if (!bus.oam_nwrite && !bus.dma_nread) both_low = both_low + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 256; i++) wcnt[i] = 0;
    rq.delete();
    both_low = 0;
  endtask

  task automatic cpu_write(input logic [7:0] v);
    bus.address_bus = 16'hFF46;
    bus.nsel = 1'b0;
    bus.nwrite = 1'b0;
    drv = 1'b1;
    drv_val = v;
    step();
    bus.nsel = 1'b1;
    bus.nwrite = 1'b1;
    drv = 1'b0;
    bus.address_bus = 16'($urandom);
  endtask

  task automatic cpu_read_chk(input string tag, input logic [7:0] exp);
    bus.address_bus = 16'hFF46;
    bus.nsel = 1'b0;
    bus.nread = 1'b0;
    #1;
    chk(tag, 32'(data_bus), 32'(exp));
    bus.nsel = 1'b1;
    bus.nread = 1'b1;
  endtask

  // Counts active samples to idle; n0 = active samples already passed.
  task automatic wait_idle(input string tag, input int n0);
    int   n;
    logic pw;
    logic [7:0] pa;
    n = n0;
    pw = 1'b1;
    pa = 8'h00;
    while (bus.dma_active && n < 2000) begin
      n++;
      pw = bus.oam_nwrite;
      pa = bus.oam_address;
      step();
    end
    chk({tag, "_cycles"}, 32'(n), 32'(1 + 2 * OAM_LEN));
    chk({tag, "_lastw"}, 32'({pw, pa}), 32'({1'b0, 8'(OAM_LEN - 1)}));
  endtask

  task automatic chk_copy(input string tag, input logic [7:0] hi);
    int bad_o, bad_w, bad_r;
    bad_o = 0;
    bad_w = 0;
    bad_r = 0;
    for (int i = 0; i < OAM_LEN; i++) begin
      if (oam[i] !== src_mem[{hi, 8'(i)}]) bad_o++;
      if (wcnt[i] != 1) bad_w++;
    end
    chk({tag, "_oam"}, 32'(bad_o), 0);
    chk({tag, "_once"}, 32'(bad_w), 0);
    chk({tag, "_nreads"}, 32'(rq.size()), 32'(OAM_LEN));
    if (rq.size() == OAM_LEN)
      for (int i = 0; i < OAM_LEN; i++)
        if (rq[i] !== {hi, 8'(i)}) bad_r++;
    chk({tag, "_raddr"}, 32'(bad_r), 0);
    chk({tag, "_both"}, 32'(both_low), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hi;
    logic [7:0] hi2;
    int n;
    int bad;
    int snap;
    logic found;

    bus.address_bus = 16'h0000;
    bus.nread = 1'b1;
    bus.nwrite = 1'b1;
    bus.nsel = 1'b1;
    for (int i = 0; i < 256; i++) begin
      oam[i] = 8'h00;
      wcnt[i] = 0;
    end
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'(i) ^ 8'h5A;

    // Reset state.
    step();
    step();
    reset = 1'b0;
    step();
    cpu_read_chk("rst_ff46", 8'hFF);
    chk("rst_active", 32'(bus.dma_active), 0);
    chk("rst_nread", 32'(bus.dma_nread), 1);
    chk("rst_nwrite", 32'(bus.oam_nwrite), 1);
    chk("rst_daddr", 32'(bus.dma_address), 0);
    chk("rst_oaddr", 32'(bus.oam_address), 0);
    chk("rst_odata", 32'(bus.oam_data), 0);
    bus.nread = 1'b0;
    #1;
    chk("hiz_nsel1", 32'(data_bus), 0);
    bus.nread = 1'b1;

    // Full copy from C1xx with the xor-5A source.
    clear_obs();
    cpu_write(8'hC1);
    chk("start_active", 32'(bus.dma_active), 1);
    chk("start_nread", 32'(bus.dma_nread), 1);
    chk("start_nwrite", 32'(bus.oam_nwrite), 1);
    step();
    chk("rd0_nread", 32'(bus.dma_nread), 0);
    chk("rd0_addr", 32'(bus.dma_address), 32'h0000_C100);
    chk("rd0_nwrite", 32'(bus.oam_nwrite), 1);
    step();
    chk("wr0_nwrite", 32'(bus.oam_nwrite), 0);
    chk("wr0_nread", 32'(bus.dma_nread), 1);
    chk("wr0_oaddr", 32'(bus.oam_address), 0);
    chk("wr0_odata", 32'(bus.oam_data), 32'h5A);
    wait_idle("c1", 2);
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++)
      if (oam[i] !== (8'(i) ^ 8'h5A)) bad++;
    chk("c1_xor5a", 32'(bad), 0);
    chk_copy("c1", 8'hC1);
    chk("hold_daddr", 32'(bus.dma_address), 32'h0000_C19F);
    chk("hold_oaddr", 32'(bus.oam_address), 32'h9F);
    chk("hold_odata", 32'(bus.oam_data), 32'h9F ^ 32'h5A);
    nwr = 0;
    for (int i = 0; i < 4; i++) step();
    chk("idle_nostrobe", 32'(nwr + rq.size() - OAM_LEN), 0);

    // Restart: 80, then 90 while reading idx 50.
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    clear_obs();
    cpu_write(8'h80);
    n = 0;
    found = 1'b0;
    while (!found && n < 500) begin
      found = !bus.dma_nread && bus.dma_address == 16'h8032;
      if (!found) begin
        n++;
        step();
      end
    end
    chk("reach_8032", 32'(found), 1);
    clear_obs();
    cpu_write(8'h90);
    chk("rs_active", 32'(bus.dma_active), 1);
    step();
    chk("rs_addr0", 32'(bus.dma_address), 32'h0000_9000);
    wait_idle("rs", 1);
    chk_copy("rs", 8'h90);

    // High source page with a CPU read mid-transfer.
    hi = 8'hE0 + 8'($urandom_range(0, 31));
    clear_obs();
    cpu_write(hi);
    for (int i = 0; i < 37; i++) step();
    cpu_read_chk("rd_mid", hi);
    wait_idle("hi", 37);
    chk_copy("hi", hi);

    // Reset while reading idx 20.
    hi2 = 8'($urandom_range(0, 223));
    for (int i = 0; i < 256; i++)
      exp_oam[i] = (i < 20) ? src_mem[{hi2, 8'(i)}] : oam[i];
    clear_obs();
    cpu_write(hi2);
    n = 0;
    found = 1'b0;
    while (!found && n < 500) begin
      found = !bus.dma_nread && bus.dma_address == {hi2, 8'd20};
      if (!found) begin
        n++;
        step();
      end
    end
    chk("reach_idx20", 32'(found), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_active", 32'(bus.dma_active), 0);
    chk("mrst_nread", 32'(bus.dma_nread), 1);
    chk("mrst_nwrite", 32'(bus.oam_nwrite), 1);
    snap = nwr;
    for (int i = 0; i < 5; i++) step();
    chk("mrst_nowr", 32'(nwr - snap), 0);
    chk("mrst_idle", 32'(bus.dma_active), 0);
    bad = 0;
    for (int i = 0; i < OAM_LEN; i++) begin
      if (oam[i] !== exp_oam[i]) bad++;
      if (i >= 20 && wcnt[i] != 0) bad++;
    end
    chk("mrst_oam", 32'(bad), 0);
    cpu_read_chk("mrst_ff46", 8'hFF);

    // Reset together with an FF46 write of 33.
    reset = 1'b1;
    bus.nsel = 1'b0;
    bus.nwrite = 1'b0;
    drv = 1'b1;
    drv_val = 8'h33;
    step();
    bus.nsel = 1'b1;
    bus.nwrite = 1'b1;
    drv = 1'b0;
    reset = 1'b0;
    chk("sim_active", 32'(bus.dma_active), 0);
    step();
    step();
    chk("sim_idle", 32'(bus.dma_active), 0);
    cpu_read_chk("sim_ff46", 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
